// File: rtl/rk8e_disk_ctrl.sv
// rk8e_disk_ctrl: RK8E-compatible disk controller moving sectors between a word store and memory by data break
module rk8e_disk_ctrl #(
    parameter logic [5:0] DEV     = 6'o74,
    parameter int         BLK_LEN = 256,
    parameter logic [4:0] F1      = 5'd1,
    parameter logic [4:0] DB0     = 5'd8,
    parameter logic [4:0] DB1     = 5'd9,
    parameter logic [4:0] DB2     = 5'd10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        clear,
    input  logic [11:0] instruction,
    input  logic [4:0]  state,
    input  logic [11:0] ac,
    input  logic        UF,
    output logic [11:0] disk_bus,
    output logic        interrupt,
    output logic        data_break_write,
    output logic        data_break_read,
    output logic        skip,
    output logic [14:0] st_addr,
    output logic [7:0]  st_word,
    output logic        st_req,
    output logic        st_we,
    output logic [11:0] st_wdata,
    input  logic [11:0] st_rdata,
    input  logic        st_ack
);
    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] RD_REQ = 3'd1;
    localparam logic [2:0] RD_BRK = 3'd2;
    localparam logic [2:0] WR_BRK = 3'd3;
    localparam logic [2:0] WR_REQ = 3'd4;
    localparam logic [7:0] LAST_FULL = 8'(BLK_LEN - 1);
    localparam logic [7:0] LAST_HALF = 8'(BLK_LEN / 2 - 1);

    logic [2:0]  fsm, op, cmd_fn;
    logic [11:0] dadr, cadr, word;
    logic [7:0]  idx;
    logic [1:0]  cmd_drv;
    logic        cmd_ie, cmd_seek, cmd_half, cmd_cyl, done, err;
    logic        iot, kill, last, busy;

    // PDP-8 numbers bits from the MSB, so instruction[0:2] lives in [11:9] and AC[10:11] in [1:0]
    assign iot  = instruction[11:9] == 3'o6 && instruction[8:3] == DEV && !UF && state == F1;
    assign op   = instruction[2:0];
    assign kill = clear || (iot && op == 3'd2 && ac[1:0] == 2'd1);
    assign last = idx == (cmd_half ? LAST_HALF : LAST_FULL);
    assign busy = fsm != IDLE;

    // Register file, IOT dispatch and the per-word transfer sequencer
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fsm      <= IDLE;
            dadr     <= '0;
            cadr     <= '0;
            word     <= '0;
            idx      <= '0;
            cmd_fn   <= '0;
            cmd_drv  <= '0;
            cmd_ie   <= 1'b0;
            cmd_seek <= 1'b0;
            cmd_half <= 1'b0;
            cmd_cyl  <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
        end else if (kill) begin
            fsm      <= IDLE;
            dadr     <= '0;
            cadr     <= '0;
            word     <= '0;
            idx      <= '0;
            cmd_fn   <= '0;
            cmd_drv  <= '0;
            cmd_ie   <= 1'b0;
            cmd_seek <= 1'b0;
            cmd_half <= 1'b0;
            cmd_cyl  <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
        end else begin
            if (iot) begin
                case (op)
                    3'd2: begin
                        if (ac[1:0] == 2'd2) begin
                            dadr <= '0;
                            done <= 1'b1;
                        end else begin
                            done <= 1'b0;
                            err  <= 1'b0;
                        end
                    end
                    3'd3: if (!busy) begin
                        dadr <= ac;
                        idx  <= '0;
                        done <= 1'b0;
                        if (cmd_fn[2:1] == 2'b00) fsm <= RD_REQ;
                        else if (cmd_fn[2:1] == 2'b10) fsm <= WR_BRK;
                        else if (cmd_fn == 3'd3) done <= cmd_seek;
                        else if (cmd_fn == 3'd2) done <= 1'b1;
                        else begin
                            done <= 1'b1;
                            err  <= 1'b1;
                        end
                    end
                    3'd4: cadr <= ac;
                    3'd6: begin
                        cmd_fn   <= ac[11:9];
                        cmd_ie   <= ac[8];
                        cmd_seek <= ac[7];
                        cmd_half <= ac[6];
                        cmd_drv  <= ac[2:1];
                        cmd_cyl  <= ac[0];
                        done     <= ac[11:10] == 2'b11;
                        err      <= ac[11:10] == 2'b11;
                    end
                    default: ;
                endcase
            end
            case (fsm)
                RD_REQ: if (st_ack) begin
                    word <= st_rdata;
                    fsm  <= RD_BRK;
                end
                RD_BRK: if (state == DB2) begin
                    cadr <= cadr + 12'd1;
                    idx  <= idx + 8'd1;
                    fsm  <= last ? IDLE : RD_REQ;
                    if (last) begin
                        done <= 1'b1;
                        dadr <= dadr + 12'd1;
                    end
                end
                WR_BRK: if (state == DB2) begin
                    word <= ac;
                    cadr <= cadr + 12'd1;
                    fsm  <= WR_REQ;
                end
                WR_REQ: if (st_ack) begin
                    idx <= idx + 8'd1;
                    fsm <= last ? IDLE : WR_BRK;
                    if (last) begin
                        done <= 1'b1;
                        dadr <= dadr + 12'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Requests follow the registered state, so a clear drops them on the next cycle
    assign data_break_write = fsm == RD_BRK;
    assign data_break_read  = fsm == WR_BRK;
    assign st_req    = fsm == RD_REQ || fsm == WR_REQ;
    assign st_we     = fsm == WR_REQ;
    assign st_wdata  = word;
    assign st_addr   = {cmd_drv, cmd_cyl, dadr};
    assign st_word   = idx;
    assign interrupt = done && cmd_ie;
    assign skip      = iot && op == 3'd1 && done;
    assign disk_bus  = (iot && op == 3'd5) ? {done, busy, 5'b0, err, 4'b0} :
                       ((data_break_write || data_break_read) && state == DB0) ? cadr :
                       (data_break_write && state == DB1) ? word : '0;
endmodule

// File: tb/tb_rk8e_disk_ctrl.sv
// tb_rk8e_disk_ctrl: randomized CPU/store environment checking rk8e_disk_ctrl against a word-level transfer model
module tb_rk8e_disk_ctrl;
    localparam logic [4:0] F0 = 5'd0, F1 = 5'd1, DB0 = 5'd8, DB1 = 5'd9, DB2 = 5'd10;

    logic        clk = 1'b0, reset = 1'b1, clear = 1'b0, UF = 1'b0, st_ack = 1'b0;
    logic [11:0] instruction = '0, ac = '0, st_rdata = '0;
    logic [4:0]  state = F0;
    logic [11:0] disk_bus, st_wdata;
    logic        interrupt, data_break_write, data_break_read, skip, st_req, st_we;
    logic [14:0] st_addr;
    logic [7:0]  st_word;

    int n_chk = 0, n_pass = 0;
    logic [11:0] mem [4096];
    logic [11:0] store [logic [22:0]];
    logic [11:0] bus_s;
    logic        skip_s;

    always #5 clk = ~clk;

    rk8e_disk_ctrl #(.DEV(6'o74), .BLK_LEN(256), .F1(F1), .DB0(DB0), .DB1(DB1), .DB2(DB2)) dut (
        .clk(clk), .reset(reset), .clear(clear), .instruction(instruction), .state(state), .ac(ac), .UF(UF),
        .disk_bus(disk_bus), .interrupt(interrupt), .data_break_write(data_break_write),
        .data_break_read(data_break_read), .skip(skip), .st_addr(st_addr), .st_word(st_word),
        .st_req(st_req), .st_we(st_we), .st_wdata(st_wdata), .st_rdata(st_rdata), .st_ack(st_ack)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0o expected %0o", tag, got, exp);
    endtask

    // One CPU IOT executed in an F1 cycle; skip and bus are captured mid-cycle
    task automatic iot(input logic [2:0] op, input logic [11:0] val);
        @(negedge clk);
        instruction = {3'o6, 6'o74, op};
        state = F1;
        ac = val;
        st_ack = 1'b0;
        #1;
        bus_s = disk_bus;
        skip_s = skip;
        @(negedge clk);
        instruction = '0;
        state = F0;
    endtask

    task automatic expect_status(input string tag, input logic [11:0] exp);
        iot(3'd5, 12'o0000);
        check(tag, bus_s, exp);
    endtask

    task automatic fill_sector(input logic [14:0] sa, input int n);
        for (int i = 0; i < n; i++) store[{sa, 8'(i)}] = 12'($urandom);
    endtask

    // Plays the store and the CPU break cycles; word i goes between store[sa,i] and mem[ca0+i]
    task automatic run_xfer(input bit wr, input int n, input int stop_at, input logic [14:0] sa, input logic [11:0] ca0);
        int si = 0, bi = 0, guard = 0, slat, blat;
        logic [11:0] a;
        slat = $urandom_range(0, 3);
        blat = $urandom_range(0, 3);
        while ((si < n || bi < n) && bi != stop_at && guard < 5000) begin
            @(negedge clk);
            guard++;
            st_ack = 1'b0;
            state = F0;
            if (st_req) begin
                if (slat > 0) slat--;
                else begin
                    check("st_addr", st_addr, sa);
                    check("st_word", st_word, si);
                    check("st_we", st_we, wr);
                    if (wr) begin
                        check("st_wdata", st_wdata, mem[12'(ca0 + si)]);
                        store[{sa, 8'(si)}] = st_wdata;
                    end else st_rdata = store[{sa, 8'(si)}];
                    st_ack = 1'b1;
                    si++;
                    slat = $urandom_range(0, 3);
                end
            end else if (data_break_write || data_break_read) begin
                if (blat > 0) blat--;
                else begin
                    a = 12'(ca0 + bi);
                    check("brk_dir", data_break_read, wr);
                    state = DB0;
                    #1;
                    check("db0_addr", disk_bus, a);
                    @(negedge clk);
                    state = DB1;
                    #1;
                    if (!wr) begin
                        check("db1_data", disk_bus, store[{sa, 8'(bi)}]);
                        mem[a] = disk_bus;
                    end
                    @(negedge clk);
                    state = DB2;
                    ac = mem[a];
                    bi++;
                    blat = $urandom_range(0, 3);
                end
            end
        end
        check("xfer_words", bi, (stop_at >= 0 && stop_at < n) ? stop_at : n);
        @(negedge clk);
        st_ack = 1'b0;
        state = F0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [11:0] ca, da;
        logic [14:0] sa;
        foreach (mem[i]) mem[i] = 12'($urandom);
        #2 reset = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_bus", disk_bus, 0);
        check("rst_flags", {interrupt, data_break_write, data_break_read, skip, st_req, st_we}, 0);
        check("rst_store", {st_addr, st_word}, 0);
        reset = 1'b1;
        @(negedge clk);
        expect_status("rst_drst", 12'o0000);

        // Full read: store 0005 into memory 0200..0577
        fill_sector(15'o00005, 256);
        iot(3'd6, 12'o0000);
        iot(3'd4, 12'o0200);
        iot(3'd3, 12'o0005);
        run_xfer(1'b0, 256, -1, 15'o00005, 12'o0200);
        iot(3'd1, 12'o0000);
        check("rd_skip", skip_s, 1);
        expect_status("rd_status", 12'o4000);

        // Half write from 7700, memory address wraps through 0000
        da = 12'($urandom);
        iot(3'd6, 12'o4100);
        iot(3'd4, 12'o7700);
        iot(3'd3, da);
        run_xfer(1'b1, 128, -1, {3'b000, da}, 12'o7700);
        expect_status("wr_status", 12'o4000);

        // Random commands, drives and lengths; interrupt follows enable once done
        for (int k = 0; k < 4; k++) begin
            logic [2:0] f;
            logic ie, half, cyl;
            logic [1:0] drv;
            int n;
            f = 3'($urandom_range(0, 1) * 4 + $urandom_range(0, 1));
            ie = (k == 0) ? 1'b1 : 1'($urandom);
            half = 1'($urandom);
            cyl = 1'($urandom);
            drv = 2'($urandom);
            ca = 12'($urandom);
            da = 12'($urandom);
            n = half ? 128 : 256;
            sa = {drv, cyl, da};
            if (!f[2]) fill_sector(sa, n);
            iot(3'd6, {f, ie, 1'b0, half, 3'($urandom), drv, cyl});
            iot(3'd4, ca);
            iot(3'd3, da);
            run_xfer(f[2], n, -1, sa, ca);
            iot(3'd1, 12'o0000);
            check("rnd_skip", skip_s, 1);
            check("rnd_irq", interrupt, ie);
            expect_status("rnd_status", 12'o4000);
            iot(3'd2, $urandom_range(0, 1) ? 12'o0003 : 12'o0000);
            check("dclr_irq", interrupt, 0);
            iot(3'd1, 12'o0000);
            check("dclr_skip", skip_s, 0);
        end

        // DLAG while busy is ignored; busy shows in status
        fill_sector(15'o00123, 256);
        iot(3'd6, 12'o0000);
        iot(3'd4, 12'o1000);
        iot(3'd3, 12'o0123);
        expect_status("busy_status", 12'o2000);
        iot(3'd3, 12'o0456);
        run_xfer(1'b0, 256, -1, 15'o00123, 12'o1000);

        // User mode suppresses IOTs
        iot(3'd2, 12'o0000);
        UF = 1'b1;
        iot(3'd3, 12'o0007);
        UF = 1'b0;
        repeat (4) @(negedge clk);
        check("uf_req", {st_req, data_break_write, data_break_read}, 0);
        expect_status("uf_status", 12'o0000);
        UF = 1'b1;
        iot(3'd6, 12'o7000);
        UF = 1'b0;
        expect_status("uf_dldc", 12'o0000);

        // Illegal function flags error and done without transferring
        iot(3'd6, 12'o7000);
        expect_status("illegal", 12'o4020);
        iot(3'd3, 12'o0001);
        repeat (3) @(negedge clk);
        check("illegal_req", {st_req, data_break_write, data_break_read}, 0);
        expect_status("illegal2", 12'o4020);
        iot(3'd2, 12'o0003);
        expect_status("dclr3", 12'o0000);

        // Seek, write-protect and recalibrate only touch done
        iot(3'd6, 12'o3000);
        iot(3'd3, 12'o0005);
        expect_status("seek_nodone", 12'o0000);
        iot(3'd6, 12'o3200);
        iot(3'd3, 12'o0005);
        expect_status("seek_done", 12'o4000);
        iot(3'd6, 12'o2000);
        expect_status("wp_cleared", 12'o0000);
        iot(3'd3, 12'o0000);
        expect_status("wp_done", 12'o4000);
        iot(3'd6, 12'o0000);
        iot(3'd2, 12'o0002);
        expect_status("recal", 12'o4000);

        // CAF clear in the middle of a read
        ca = 12'($urandom);
        da = 12'($urandom);
        fill_sector({3'b000, da}, 256);
        iot(3'd6, 12'o0400);
        iot(3'd4, ca);
        iot(3'd3, da);
        run_xfer(1'b0, 256, 10 + $urandom_range(0, 20), {3'b000, da}, ca);
        check("pre_clear_req", st_req, 1);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        check("clr_req", {st_req, data_break_write, data_break_read, interrupt}, 0);
        check("clr_addr", st_addr, 0);
        expect_status("clr_status", 12'o0000);

        // DCLR controller clear in the middle of a write
        ca = 12'($urandom);
        da = 12'($urandom);
        iot(3'd6, 12'o4003);
        iot(3'd4, ca);
        iot(3'd3, da);
        run_xfer(1'b1, 256, 5, {3'b011, da}, ca);
        check("pre_dclr_req", st_req, 1);
        iot(3'd2, 12'o0001);
        check("dclr1_req", {st_req, data_break_write, data_break_read}, 0);
        check("dclr1_addr", st_addr, 0);
        expect_status("dclr1_status", 12'o0000);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
